// File: rtl/gcn_argmax_reader_pkg.sv
// gcn_argmax_reader_pkg: shared sizes, row element type and reader FSM states.
package gcn_argmax_reader_pkg;
  localparam int FEATURE_ROWS = 6;
  localparam int WEIGHT_COLS = 3;
  localparam int DOT_PROD_WIDTH = 16;
  localparam int MAX_ADDRESS_WIDTH = 2;
  localparam int COO_BW = $clog2(FEATURE_ROWS);
  typedef logic [DOT_PROD_WIDTH-1:0] elem_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} argmax_state_e;
endpackage

// File: rtl/gcn_argmax_reader_cmp.sv
// gcn_argmax_reader_cmp: combinational unsigned argmax over one row; ties keep the lowest column.
module gcn_argmax_reader_cmp
  import gcn_argmax_reader_pkg::*;
(
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] i_row,
  output logic [MAX_ADDRESS_WIDTH-1:0]          o_idx,
  output elem_t                                 o_max
);
  always_comb begin
    o_idx = '0;
    o_max = i_row[DOT_PROD_WIDTH-1:0];
    for (int c = 1; c < WEIGHT_COLS; c++)
      if (i_row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] > o_max) begin
        o_max = i_row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
        o_idx = MAX_ADDRESS_WIDTH'(c);
      end
  end
endmodule

// File: rtl/gcn_argmax_reader.sv
// gcn_argmax_reader: walks the FM*WM*ADJ rows after done_comb rises and stores one argmax class per node.
module gcn_argmax_reader
  import gcn_argmax_reader_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  done_comb,
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_adj_row_in,
  output logic [COO_BW-1:0]                     read_argmax,
  output logic                                  row_valid,
  output logic [COO_BW-1:0]                     row_idx,
  output logic [FEATURE_ROWS*MAX_ADDRESS_WIDTH-1:0] max_addi_answer,
  output logic                                  done
);
  localparam logic [COO_BW-1:0] LAST_ROW = COO_BW'(FEATURE_ROWS-1);
  argmax_state_e r_state;
  logic r_dc;
  logic [COO_BW-1:0] r_row;
  logic w_start, w_issue, w_cap;
  logic [COO_BW-1:0] w_cap_idx;
  logic [MAX_ADDRESS_WIDTH-1:0] w_idx;
  elem_t w_max_unused;
  assign w_start = done_comb & ~r_dc & (r_state == IDLE || r_state == DONE);
  assign w_issue = r_state == ISSUE;
  assign read_argmax = r_row;
  gcn_argmax_reader_cmp u_cmp (
    .i_row (fm_wm_adj_row_in),
    .o_idx (w_idx),
    .o_max (w_max_unused)
  );
  // Each issued address travels with its valid bit until its data returns.
  if (READ_LATENCY == 0) begin : g_comb
    assign w_cap = w_issue;
    assign w_cap_idx = r_row;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0] r_vp;
    logic [COO_BW-1:0] r_ap [READ_LATENCY];
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_vp <= '0;
        for (int i = 0; i < READ_LATENCY; i++) r_ap[i] <= '0;
      end else begin
        r_vp[0] <= w_issue;
        r_ap[0] <= r_row;
        for (int i = 1; i < READ_LATENCY; i++) begin
          r_vp[i] <= r_vp[i-1];
          r_ap[i] <= r_ap[i-1];
        end
      end
    assign w_cap = r_vp[READ_LATENCY-1];
    assign w_cap_idx = r_ap[READ_LATENCY-1];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_dc <= 1'b0;
      r_row <= '0;
      row_valid <= 1'b0;
      row_idx <= '0;
      max_addi_answer <= '0;
      done <= 1'b0;
    end else begin
      r_dc <= done_comb;
      row_valid <= w_cap;
      if (w_cap) begin
        row_idx <= w_cap_idx;
        max_addi_answer[w_cap_idx*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH] <= w_idx;
      end
      if (w_issue) begin
        r_row <= r_row == LAST_ROW ? r_row : r_row + 1'b1;
        if (r_row == LAST_ROW) r_state <= READ_LATENCY == 0 ? DONE : DRAIN;
      end
      if (w_cap && w_cap_idx == LAST_ROW) begin
        r_state <= DONE;
        done <= 1'b1;
      end
      if (w_start) begin
        r_state <= ISSUE;
        r_row <= '0;
        done <= 1'b0;
        max_addi_answer <= '0;
      end
    end
endmodule
